// File: rtl/id_queue_bank.sv
// Four independent per-ID circular FIFOs sharing one enqueue port, drained through a
// round-robin dequeue port whose offer stays stable while the consumer back-pressures.
module id_queue_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [1:0]        enq_id,
  input  logic [DATA_W-1:0] enq_data,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [1:0]        deq_id,
  output logic [DATA_W-1:0] deq_data,
  output logic [3:0]        full,
  output logic [3:0]        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DATA_W-1:0] mem [4][DEPTH];
  ptr_t              rd_ptr [4];
  ptr_t              wr_ptr [4];
  cnt_t              count  [4];

  logic [1:0] last_grant;
  logic [1:0] locked_id;
  logic       lock;

  logic [1:0] grant;
  logic [1:0] idx;
  logic       found;
  logic       enq_fire;
  logic       deq_fire;
  logic [3:0] push;
  logic [3:0] pop;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]  = (count[i] == CNT_W'(DEPTH));
      empty[i] = (count[i] == '0);
    end
  end

  // Readiness reflects current occupancy only, so a full queue refuses even when it is being drained.
  assign enq_ready = !full[enq_id];
  assign enq_fire  = enq_valid && enq_ready;
  assign deq_valid = |(~empty);
  assign deq_fire  = deq_valid && deq_ready;

  // Round-robin search starting just after the last queue that was drained.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!found && !empty[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign deq_id = !deq_valid ? 2'd0 : (lock ? locked_id : grant);

  always_comb begin
    deq_data = '0;
    if (deq_valid) deq_data = mem[deq_id][rd_ptr[deq_id]];
  end

  assign push = enq_fire ? (4'b0001 << enq_id) : 4'b0000;
  assign pop  = deq_fire ? (4'b0001 << deq_id) : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      last_grant <= 2'd3;
      lock       <= 1'b0;
      locked_id  <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_t'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + ptr_t'(1);
        if (push[i] && !pop[i])      count[i] <= count[i] + cnt_t'(1);
        else if (pop[i] && !push[i]) count[i] <= count[i] - cnt_t'(1);
      end
      if (deq_fire) begin
        last_grant <= deq_id;
        lock       <= 1'b0;
      end else if (deq_valid) begin
        lock      <= 1'b1;
        locked_id <= deq_id;
      end
    end
  end

  // NOTE: the entry storage has no reset; its contents are only observed when the count says valid.
  always_ff @(posedge clock) begin
    if (enq_fire) mem[enq_id][wr_ptr[enq_id]] <= enq_data;
  end

endmodule
